// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU bus bridge.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    ROM,
    RAM,
    IO
  } region_e;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational region decode: ROM > RAM > IO priority, offset relative to the hit base.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE      = 32'h0000_0000,
  parameter int unsigned ROM_SIZE_LOG2 = 12,
  parameter logic [31:0] RAM_BASE      = 32'h0000_1000,
  parameter int unsigned RAM_SIZE_LOG2 = 12,
  parameter logic [31:0] IO_BASE       = 32'hF000_0000,
  parameter int unsigned IO_SIZE_LOG2  = 16
) (
  input  logic [31:0] addr_i,
  output region_e     region_o,
  output logic [31:0] offset_o
);

  always_comb begin
    region_o = NONE;
    offset_o = '0;
    if (addr_i[31:ROM_SIZE_LOG2] == ROM_BASE[31:ROM_SIZE_LOG2]) begin
      region_o = ROM;
      offset_o = addr_i - ROM_BASE;
    end else if (addr_i[31:RAM_SIZE_LOG2] == RAM_BASE[31:RAM_SIZE_LOG2]) begin
      region_o = RAM;
      offset_o = addr_i - RAM_BASE;
    end else if (addr_i[31:IO_SIZE_LOG2] == IO_BASE[31:IO_SIZE_LOG2]) begin
      region_o = IO;
      offset_o = addr_i - IO_BASE;
    end
  end

endmodule

// File: rtl/bus_bridge.sv
// CPU bus to ROM/RAM/IO slave bridge with error responses for illegal accesses.
// Define BUS_TIMEOUT_EN to bound the slave wait to TIMEOUT_CYCLES access cycles.
module bus_bridge
  import bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
  parameter int unsigned ROM_SIZE_LOG2  = 12,
  parameter logic [31:0] RAM_BASE       = 32'h0000_1000,
  parameter int unsigned RAM_SIZE_LOG2  = 12,
  parameter logic [31:0] IO_BASE        = 32'hF000_0000,
  parameter int unsigned IO_SIZE_LOG2   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] busAddress,
  input  logic [31:0] busDataOut,
  input  logic        busValid,
  input  logic        busInstr,
  input  logic        busWriteEnable,
  output logic [31:0] busDataIn,
  output logic        busReady,
  output logic        busError,
  output logic [31:0] slaveAddress,
  output logic [31:0] slaveDataOut,
  output logic        slaveWriteEnable,
  output logic        romSel,
  output logic        ramSel,
  output logic        ioSel,
  input  logic [31:0] romDataIn,
  input  logic [31:0] ramDataIn,
  input  logic [31:0] ioDataIn,
  input  logic        romReady,
  input  logic        ramReady,
  input  logic        ioReady
);

  state_e      state_q, state_d;
  region_e     region_q, region_d, dec_region;
  logic [31:0] dec_offset;
  logic [31:0] off_q, off_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        we_q, we_d, err_q, err_d;
  logic        sel_ready;
  logic [31:0] sel_rdata;
`ifdef BUS_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  bus_addr_decoder #(
    .ROM_BASE      (ROM_BASE),
    .ROM_SIZE_LOG2 (ROM_SIZE_LOG2),
    .RAM_BASE      (RAM_BASE),
    .RAM_SIZE_LOG2 (RAM_SIZE_LOG2),
    .IO_BASE       (IO_BASE),
    .IO_SIZE_LOG2  (IO_SIZE_LOG2)
  ) u_dec (
    .addr_i   (busAddress),
    .region_o (dec_region),
    .offset_o (dec_offset)
  );

  // Only the selected slave's ready/data are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    case (region_q)
      ROM: begin sel_ready = romReady; sel_rdata = romDataIn; end
      RAM: begin sel_ready = ramReady; sel_rdata = ramDataIn; end
      IO:  begin sel_ready = ioReady;  sel_rdata = ioDataIn;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (busValid) begin
          off_d   = dec_offset;
          wdata_d = busDataOut;
          we_d    = busWriteEnable;
          if (dec_region == NONE || (dec_region == ROM && busWriteEnable) ||
              (dec_region == IO && busInstr)) begin
            region_d = NONE;
            err_d    = 1'b1;
            rdata_d  = ERR_RDATA;
            state_d  = RESPOND;
          end else begin
            region_d = dec_region;
            err_d    = 1'b0;
            state_d  = ACCESS;
`ifdef BUS_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = RESPOND;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 32'd1;
`endif
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      region_q <= NONE;
      off_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign romSel           = (state_q == ACCESS) && (region_q == ROM);
  assign ramSel           = (state_q == ACCESS) && (region_q == RAM);
  assign ioSel            = (state_q == ACCESS) && (region_q == IO);
  assign slaveWriteEnable = (state_q == ACCESS) && we_q;
  assign slaveAddress     = off_q;
  assign slaveDataOut     = wdata_q;
  assign busReady         = (state_q == RESPOND);
  assign busError         = (state_q == RESPOND) && err_q;
  assign busDataIn        = rdata_q;

endmodule
